// File: rtl/joker_cmd_dispatch.sv
// Joker TV command front end: fetches the command byte from each EP2 OUT
// packet, hands it to the sub-blocks, then commits the EP1 IN reply and re-arms.
module joker_cmd_dispatch #(
    parameter logic [23:0] TIMEOUT = 24'd5_000_000,
    parameter int          RD_LAT  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        buf_out_hasdata,
    input  logic [9:0]  buf_out_len,
    input  logic [7:0]  buf_out_q,
    output logic [10:0] buf_out_addr,
    output logic        own_buf,
    output logic        buf_out_arm,
    input  logic        buf_out_arm_ack,
    output logic [7:0]  j_cmd,
    input  logic        ack_i,
    input  logic [10:0] sub_commit_len,
    input  logic        usb_in_ready,
    output logic        usb_in_commit,
    output logic [10:0] usb_in_commit_len,
    input  logic        usb_in_commit_ack,
    output logic        timeout_o,
    output logic [7:0]  err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DISPATCH,
        S_RELEASE,
        S_COMMIT,
        S_ARM
    } state_t;

    localparam logic [23:0] RD_LAT_T = 24'(RD_LAT);
    localparam logic [23:0] TO_LAST  = TIMEOUT - 24'd1;

    state_t      state_q;
    logic        seen_empty_q;
    logic [23:0] timer_q;
    logic [10:0] addr_q;
    logic        own_q;
    logic        arm_q;
    logic [7:0]  cmd_q;
    logic        commit_q;
    logic [10:0] commit_len_q;
    logic        timeout_q;
    logic [7:0]  err_q;
    logic [7:0]  err_d;

    // Saturating successor of the error counter.
    always_comb begin
        err_d = (err_q == 8'hFF) ? 8'hFF : err_q + 8'd1;
    end

    // Command sequencer; every output is a register written here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            seen_empty_q <= 1'b1;
            timer_q      <= '0;
            addr_q       <= '0;
            own_q        <= 1'b0;
            arm_q        <= 1'b0;
            cmd_q        <= 8'h00;
            commit_q     <= 1'b0;
            commit_len_q <= '0;
            timeout_q    <= 1'b0;
            err_q        <= 8'h00;
        end else begin
            timeout_q <= 1'b0;
            // A packet is only taken once the buffer has been seen empty,
            // so a buffer left full after re-arm is not dispatched twice.
            if (!buf_out_hasdata) begin
                seen_empty_q <= 1'b1;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (buf_out_hasdata && seen_empty_q) begin
                        seen_empty_q <= 1'b0;
                        if (buf_out_len == 10'd0) begin
                            err_q   <= err_d;
                            arm_q   <= 1'b1;
                            state_q <= S_ARM;
                        end else begin
                            own_q   <= 1'b1;
                            addr_q  <= '0;
                            timer_q <= '0;
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (timer_q == RD_LAT_T) begin
                        own_q   <= 1'b0;
                        timer_q <= '0;
                        if (buf_out_q == 8'h00) begin
                            err_q   <= err_d;
                            arm_q   <= 1'b1;
                            state_q <= S_ARM;
                        end else begin
                            cmd_q   <= buf_out_q;
                            state_q <= S_DISPATCH;
                        end
                    end else begin
                        timer_q <= timer_q + 24'd1;
                    end
                end
                S_DISPATCH: begin
                    // Ack is checked first so it wins over a same-cycle timeout.
                    if (ack_i) begin
                        commit_len_q <= sub_commit_len;
                        cmd_q        <= 8'h00;
                        state_q      <= S_RELEASE;
                    end else if (timer_q == TO_LAST) begin
                        commit_len_q <= '0;
                        cmd_q        <= 8'h00;
                        timeout_q    <= 1'b1;
                        err_q        <= err_d;
                        state_q      <= S_RELEASE;
                    end else begin
                        timer_q <= timer_q + 24'd1;
                    end
                end
                S_RELEASE: begin
                    if (!ack_i) begin
                        if (commit_len_q != 11'd0) begin
                            commit_q <= usb_in_ready;
                            state_q  <= S_COMMIT;
                        end else begin
                            arm_q   <= 1'b1;
                            state_q <= S_ARM;
                        end
                    end
                end
                S_COMMIT: begin
                    if (!commit_q) begin
                        commit_q <= usb_in_ready;
                    end else if (usb_in_commit_ack) begin
                        commit_q <= 1'b0;
                        arm_q    <= 1'b1;
                        state_q  <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (buf_out_arm_ack) begin
                        arm_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign buf_out_addr      = addr_q;
    assign own_buf           = own_q;
    assign buf_out_arm       = arm_q;
    assign j_cmd             = cmd_q;
    assign usb_in_commit     = commit_q;
    assign usb_in_commit_len = commit_len_q;
    assign timeout_o         = timeout_q;
    assign err_cnt           = err_q;

endmodule
